icache_mshr_sched: RTL and testbench

// - Shared-resource scheduler for the icache MSHR entry array.
// - Picks the free entry for each new lookup and round-robin arbitrates entry data-RAM read requests onto the single data-RAM read port.
// - Round-robin arbitrates entry linefill requests into a 2-deep output queue driving the downstream request channel.
// - Sits between the MSHR entry array and the data RAM / downstream interface.

---
 rtl/icache_mshr_sched_pkg.sv | 18 +
 rtl/icache_mshr_sched_if.sv | 37 +++
 rtl/icache_mshr_sched_chk.sv | 10 +
 rtl/icache_mshr_sched_rr_arb.sv | 49 ++++
 rtl/icache_mshr_sched.sv | 117 +++++++++++
 tb/tb_icache_mshr_sched.sv | 298 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/icache_mshr_sched_pkg.sv
// Shared types and sizing for the icache MSHR scheduler slice.
package icache_mshr_sched_pkg;

  localparam int MSHR_ENTRY_NUM = 8;

  typedef logic [$clog2(MSHR_ENTRY_NUM)-1:0] mshr_idx_t;

  typedef struct packed {
    logic [6:0] set_idx;
    logic [1:0] way;
  } dataram_rd_pld_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  src;
  } pc_req_t;

endpackage

// File: rtl/icache_mshr_sched_if.sv
// Handshake bundle between the MSHR entry array, data RAM and downstream channel.
interface icache_mshr_sched_if
  import icache_mshr_sched_pkg::*;
#(
  parameter int ENTRY_NUM = MSHR_ENTRY_NUM
);
  logic                                   alloc_req;
  logic            [ENTRY_NUM-1:0]        v_alloc_vld;
  logic            [ENTRY_NUM-1:0]        v_entry_en;
  logic                                   alloc_full;
  logic            [ENTRY_NUM-1:0]        v_dataram_rd_vld;
  dataram_rd_pld_t [ENTRY_NUM-1:0]        v_dataram_rd_pld;
  logic            [ENTRY_NUM-1:0]        v_dataram_rd_rdy;
  logic                                   dataram_rd_vld;
  dataram_rd_pld_t                        dataram_rd_pld;
  logic                                   dataram_rd_rdy;
  logic            [ENTRY_NUM-1:0]        v_txreq_vld;
  pc_req_t         [ENTRY_NUM-1:0]        v_txreq_pld;
  logic            [ENTRY_NUM-1:0]        v_txreq_rdy;
  logic                                   txreq_vld;
  pc_req_t                                txreq_pld;
  logic                                   txreq_rdy;

  modport slave (
    input  alloc_req, v_alloc_vld, v_dataram_rd_vld, v_dataram_rd_pld, dataram_rd_rdy,
           v_txreq_vld, v_txreq_pld, txreq_rdy,
    output v_entry_en, alloc_full, v_dataram_rd_rdy, dataram_rd_vld, dataram_rd_pld,
           v_txreq_rdy, txreq_vld, txreq_pld
  );

  modport master (
    output alloc_req, v_alloc_vld, v_dataram_rd_vld, v_dataram_rd_pld, dataram_rd_rdy,
           v_txreq_vld, v_txreq_pld, txreq_rdy,
    input  v_entry_en, alloc_full, v_dataram_rd_rdy, dataram_rd_vld, dataram_rd_pld,
           v_txreq_rdy, txreq_vld, txreq_pld
  );
endinterface

// File: rtl/icache_mshr_sched_chk.sv
// Invariant checks for the linefill output queue occupancy.
module icache_mshr_sched_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] cnt
);

  a_cnt_legal: assert property (@(posedge clk) disable iff (!rst_n) (cnt <= 2'd2));

endmodule

// File: rtl/icache_mshr_sched_rr_arb.sv
// Round-robin arbiter; search starts at an internal pointer that moves past each accepted winner.
module icache_rr_arb #(
  parameter int ENTRY_NUM = 8,
  localparam int IDX_W = $clog2(ENTRY_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ENTRY_NUM-1:0] req,
  input  logic                 adv,
  output logic [ENTRY_NUM-1:0] grant_oh,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0] ptr_r;
  logic             found_s;
  logic [IDX_W-1:0] idx_s;

  // first requester at or after the pointer, wrapping
  always_comb begin
    logic [IDX_W-1:0] cand;
    found_s = 1'b0;
    idx_s   = '0;
    cand    = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      cand = ptr_r + IDX_W'(i);
      if (!found_s && req[cand]) begin
        found_s = 1'b1;
        idx_s   = cand;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_idx = idx_s;
  assign grant_oh  = found_s ? ({{(ENTRY_NUM-1){1'b0}}, 1'b1} << idx_s) : {ENTRY_NUM{1'b0}};

  // pointer advances one past the winner on an accepted grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (adv) begin
      ptr_r <= idx_s + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/icache_mshr_sched.sv
// MSHR shared-resource scheduler: free-entry picker, data-RAM read arbiter and
// linefill arbiter feeding a 2-deep registered downstream queue.
module icache_mshr_sched
  import icache_mshr_sched_pkg::*;
#(
  parameter int ENTRY_NUM = MSHR_ENTRY_NUM,
  parameter int TXQ_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  icache_mshr_sched_if.slave  bus
);

  localparam logic [1:0] TXQ_FULL = 2'(TXQ_DEPTH);

  logic [ENTRY_NUM-1:0] entry_en_s;
  logic                 alloc_found_s;
  logic [ENTRY_NUM-1:0] rd_grant_oh_s;
  mshr_idx_t            rd_grant_idx_s;
  logic [ENTRY_NUM-1:0] tx_grant_oh_s;
  mshr_idx_t            tx_grant_idx_s;
  logic                 rd_hs_s;
  logic                 pop_s;
  logic                 push_en_s;
  logic                 push_s;
  logic [1:0]           wr_pos_s;
  logic [1:0]           cnt_nxt_s;
  pc_req_t              q0_nxt_s;
  pc_req_t              q1_nxt_s;
  logic [1:0]           cnt_r;
  pc_req_t              q0_r;
  pc_req_t              q1_r;

  // lowest-index free entry gets the allocate strobe
  always_comb begin
    entry_en_s    = '0;
    alloc_found_s = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!alloc_found_s && bus.v_alloc_vld[i]) begin
        alloc_found_s = 1'b1;
        entry_en_s[i] = bus.alloc_req;
      end else begin
        alloc_found_s = alloc_found_s;
      end
    end
  end

  assign bus.alloc_full = ~|bus.v_alloc_vld;
  assign bus.v_entry_en = entry_en_s;

  assign rd_hs_s = bus.dataram_rd_vld & bus.dataram_rd_rdy;

  icache_rr_arb #(.ENTRY_NUM(ENTRY_NUM)) u_rd_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.v_dataram_rd_vld),
    .adv       (rd_hs_s),
    .grant_oh  (rd_grant_oh_s),
    .grant_idx (rd_grant_idx_s)
  );

  assign bus.dataram_rd_vld   = |bus.v_dataram_rd_vld;
  assign bus.dataram_rd_pld   = bus.v_dataram_rd_pld[rd_grant_idx_s];
  assign bus.v_dataram_rd_rdy = rd_grant_oh_s & {ENTRY_NUM{bus.dataram_rd_rdy}};

  icache_rr_arb #(.ENTRY_NUM(ENTRY_NUM)) u_tx_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.v_txreq_vld),
    .adv       (push_s),
    .grant_oh  (tx_grant_oh_s),
    .grant_idx (tx_grant_idx_s)
  );

  // queue next state; a full queue accepts only when the head leaves this cycle
  always_comb begin
    pop_s     = (cnt_r != 2'd0) & bus.txreq_rdy;
    push_en_s = (cnt_r < TXQ_FULL) | pop_s;
    push_s    = (|tx_grant_oh_s) & push_en_s;
    cnt_nxt_s = cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    wr_pos_s  = cnt_r - {1'b0, pop_s};
    q0_nxt_s  = pop_s ? q1_r : q0_r;
    q1_nxt_s  = q1_r;
    if (push_s && (wr_pos_s == 2'd0)) begin
      q0_nxt_s = bus.v_txreq_pld[tx_grant_idx_s];
    end else if (push_s) begin
      q1_nxt_s = bus.v_txreq_pld[tx_grant_idx_s];
    end else begin
      q1_nxt_s = q1_nxt_s;
    end
  end

  assign bus.v_txreq_rdy = tx_grant_oh_s & {ENTRY_NUM{push_en_s}};

  // queue storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 2'd0;
      q0_r  <= '0;
      q1_r  <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
      q0_r  <= q0_nxt_s;
      q1_r  <= q1_nxt_s;
    end
  end

  assign bus.txreq_vld = (cnt_r != 2'd0);
  assign bus.txreq_pld = q0_r;

  icache_mshr_sched_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt_r)
  );

endmodule

// File: tb/tb_icache_mshr_sched.sv
// Directed self-checking bench for icache_mshr_sched (allocation, RR arbitration, queue, reset).
module tb_icache_mshr_sched;
  import icache_mshr_sched_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  icache_mshr_sched_if #(.ENTRY_NUM(8)) bus ();

  icache_mshr_sched #(.ENTRY_NUM(8), .TXQ_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic dataram_rd_pld_t rd_pld(int i);
    dataram_rd_pld_t p;
    p.set_idx = 7'(i * 5 + 1);
    p.way     = 2'(i);
    return p;
  endfunction

  function automatic pc_req_t tx_pld(int i);
    pc_req_t p;
    p.addr = 16'h1000 + 16'(i * 64);
    p.src  = 3'(i);
    return p;
  endfunction

  function automatic logic [7:0] oh(int i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (bus.txreq_vld !== 1'b0) begin
      bad++; $display("FAIL reset_txreq_vld got=%b exp=0", bus.txreq_vld);
    end
    total++;
    if (bus.alloc_full !== 1'b1 || bus.v_entry_en !== 8'h00) begin
      bad++; $display("FAIL reset_alloc got full=%b en=%h exp full=1 en=00", bus.alloc_full, bus.v_entry_en);
    end
    total++;
    if (bus.dataram_rd_vld !== 1'b0 || bus.v_txreq_rdy !== 8'h00) begin
      bad++; $display("FAIL reset_idle got rd_vld=%b tx_rdy=%h exp 0/00", bus.dataram_rd_vld, bus.v_txreq_rdy);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_alloc();
    bus.v_alloc_vld = 8'b1010_0000;
    bus.alloc_req   = 1'b1;
    #1;
    total++;
    if (bus.v_entry_en !== 8'b0010_0000 || bus.alloc_full !== 1'b0) begin
      bad++; $display("FAIL alloc_lowest got en=%b full=%b exp en=00100000 full=0", bus.v_entry_en, bus.alloc_full);
    end
    bus.alloc_req = 1'b0;
    #1;
    total++;
    if (bus.v_entry_en !== 8'h00) begin
      bad++; $display("FAIL alloc_noreq got en=%b exp 00000000", bus.v_entry_en);
    end
    bus.v_alloc_vld = 8'h00;
    bus.alloc_req   = 1'b1;
    #1;
    total++;
    if (bus.alloc_full !== 1'b1 || bus.v_entry_en !== 8'h00) begin
      bad++; $display("FAIL alloc_full got full=%b en=%b exp full=1 en=0", bus.alloc_full, bus.v_entry_en);
    end
    bus.alloc_req = 1'b0;
    step();
  endtask

  task automatic test_rr();
    bus.v_dataram_rd_vld = 8'hFF;
    bus.dataram_rd_rdy   = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      total++;
      if (bus.v_dataram_rd_rdy !== oh(c % 8) || bus.dataram_rd_pld !== rd_pld(c % 8)) begin
        bad++; $display("FAIL rr_cycle%0d got grant=%b pld=%h exp grant=%b pld=%h",
                        c, bus.v_dataram_rd_rdy, bus.dataram_rd_pld, oh(c % 8), rd_pld(c % 8));
      end
      step();
    end
    // pointer now sits on entry 3; entry 3 drops its request
    bus.v_dataram_rd_vld = 8'b1111_0111;
    @(negedge clk);
    total++;
    if (bus.v_dataram_rd_rdy !== oh(4)) begin
      bad++; $display("FAIL rr_skip_dropped got=%b exp=%b", bus.v_dataram_rd_rdy, oh(4));
    end
    step();
    // one grant to entry 7 brings the pointer back to 0
    bus.v_dataram_rd_vld = 8'b1000_0000;
    @(negedge clk);
    total++;
    if (bus.v_dataram_rd_rdy !== oh(7)) begin
      bad++; $display("FAIL rr_entry7 got=%b exp=%b", bus.v_dataram_rd_rdy, oh(7));
    end
    step();
  endtask

  task automatic test_backpressure();
    bus.v_dataram_rd_vld = 8'b0010_0100;
    bus.dataram_rd_rdy   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (bus.v_dataram_rd_rdy !== 8'h00 || bus.dataram_rd_vld !== 1'b1 || bus.dataram_rd_pld !== rd_pld(2)) begin
        bad++; $display("FAIL bp_stall%0d got rdy=%b vld=%b pld=%h exp rdy=0 vld=1 pld=%h",
                        c, bus.v_dataram_rd_rdy, bus.dataram_rd_vld, bus.dataram_rd_pld, rd_pld(2));
      end
      step();
    end
    bus.dataram_rd_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (bus.v_dataram_rd_rdy !== oh(2)) begin
      bad++; $display("FAIL bp_release_first got=%b exp=%b", bus.v_dataram_rd_rdy, oh(2));
    end
    step();
    @(negedge clk);
    total++;
    if (bus.v_dataram_rd_rdy !== oh(5) || bus.dataram_rd_pld !== rd_pld(5)) begin
      bad++; $display("FAIL bp_release_second got=%b pld=%h exp=%b pld=%h",
                      bus.v_dataram_rd_rdy, bus.dataram_rd_pld, oh(5), rd_pld(5));
    end
    step();
    bus.v_dataram_rd_vld = 8'h00;
  endtask

  task automatic test_queue_fill();
    logic [7:0] g;
    int         exp_order [3];
    exp_order = '{1, 4, 6};
    bus.txreq_rdy   = 1'b0;
    bus.v_txreq_vld = 8'b0101_0010;
    // first two cycles: entries 1 and 4 enter the queue
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      g = bus.v_txreq_rdy;
      total++;
      if (g !== oh(exp_order[c])) begin
        bad++; $display("FAIL qfill_grant%0d got=%b exp=%b", c, g, oh(exp_order[c]));
      end
      step();
      bus.v_txreq_vld = bus.v_txreq_vld & ~g;
    end
    // queue full: entry 6 must wait, head stays stable
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (bus.v_txreq_rdy !== 8'h00 || bus.txreq_vld !== 1'b1 || bus.txreq_pld !== tx_pld(1)) begin
        bad++; $display("FAIL qfill_full%0d got rdy=%b vld=%b pld=%h exp rdy=0 vld=1 pld=%h",
                        c, bus.v_txreq_rdy, bus.txreq_vld, bus.txreq_pld, tx_pld(1));
      end
      step();
    end
    bus.txreq_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      g = bus.v_txreq_rdy;
      total++;
      if (bus.txreq_vld !== 1'b1 || bus.txreq_pld !== tx_pld(exp_order[c])) begin
        bad++; $display("FAIL qdrain_out%0d got vld=%b pld=%h exp vld=1 pld=%h",
                        c, bus.txreq_vld, bus.txreq_pld, tx_pld(exp_order[c]));
      end
      if (c == 0) begin
        total++;
        if (g !== oh(6)) begin
          bad++; $display("FAIL qdrain_push_on_pop got=%b exp=%b", g, oh(6));
        end
      end
      step();
      bus.v_txreq_vld = bus.v_txreq_vld & ~g;
    end
    @(negedge clk);
    total++;
    if (bus.txreq_vld !== 1'b0) begin
      bad++; $display("FAIL qdrain_empty got=%b exp=0", bus.txreq_vld);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int seq [3];
    seq = '{0, 3, 5};
    bus.txreq_rdy   = 1'b1;
    bus.v_txreq_vld = 8'b0010_1001;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++;
      if (bus.v_txreq_rdy !== oh(seq[c % 3])) begin
        bad++; $display("FAIL b2b_grant%0d got=%b exp=%b", c, bus.v_txreq_rdy, oh(seq[c % 3]));
      end
      if (c > 0) begin
        total++;
        if (bus.txreq_vld !== 1'b1 || bus.txreq_pld !== tx_pld(seq[(c - 1) % 3])) begin
          bad++; $display("FAIL b2b_out%0d got vld=%b pld=%h exp vld=1 pld=%h",
                          c, bus.txreq_vld, bus.txreq_pld, tx_pld(seq[(c - 1) % 3]));
        end
      end
      step();
    end
    bus.v_txreq_vld = 8'h00;
    step();
    step();
  endtask

  task automatic test_mid_reset();
    logic [7:0] g;
    // fill the queue with entries 2,3 and move the read pointer past entry 3
    bus.txreq_rdy        = 1'b0;
    bus.v_txreq_vld      = 8'b0000_1100;
    bus.v_dataram_rd_vld = 8'b0000_1000;
    bus.dataram_rd_rdy   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      g = bus.v_txreq_rdy;
      step();
      bus.v_txreq_vld      = bus.v_txreq_vld & ~g;
      bus.v_dataram_rd_vld = 8'h00;
    end
    @(negedge clk);
    total++;
    if (bus.txreq_vld !== 1'b1) begin
      bad++; $display("FAIL mrst_prefill got=%b exp=1", bus.txreq_vld);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.txreq_vld !== 1'b0) begin
      bad++; $display("FAIL mrst_async_clear got=%b exp=0", bus.txreq_vld);
    end
    bus.v_txreq_vld      = 8'b0100_0100;
    bus.v_dataram_rd_vld = 8'b0100_0100;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.v_txreq_rdy !== oh(2) || bus.v_dataram_rd_rdy !== oh(2)) begin
      bad++; $display("FAIL mrst_ptr_zero got tx=%b rd=%b exp tx=%b rd=%b",
                      bus.v_txreq_rdy, bus.v_dataram_rd_rdy, oh(2), oh(2));
    end
    total++;
    if (bus.txreq_vld !== 1'b0) begin
      bad++; $display("FAIL mrst_queue_empty got=%b exp=0", bus.txreq_vld);
    end
    step();
    bus.v_txreq_vld      = 8'h00;
    bus.v_dataram_rd_vld = 8'h00;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.alloc_req        = 1'b0;
    bus.v_alloc_vld      = 8'h00;
    bus.v_dataram_rd_vld = 8'h00;
    bus.dataram_rd_rdy   = 1'b0;
    bus.v_txreq_vld      = 8'h00;
    bus.txreq_rdy        = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.v_dataram_rd_pld[i] = rd_pld(i);
      bus.v_txreq_pld[i]      = tx_pld(i);
    end
    test_reset();
    test_alloc();
    test_rr();
    test_backpressure();
    test_queue_fill();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
